// File: rtl/msg_to_pkt_queue.sv
// Reverse-path packet generation queue: gathers WISHBONE message chunks into
// QUEUE_DEPTH slots and hands out one complete packet per message.
module msg_to_pkt_queue #(
  parameter int FLIT_WIDTH          = 64,
  parameter int BUS_ADDRESS_WIDTH   = 32,
  parameter int BUS_DATA_WIDTH      = 32,
  parameter int BUS_SEL_WIDTH       = 4,
  parameter int MAX_BURST_LENGTH    = 8,
  parameter int MAX_PACKET_LENGTH   = 5,
  parameter int QUEUE_DEPTH         = 4,
  parameter int N_BITS_POINTER      = 2,
  parameter int N_BITS_BURST_LENGTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [BUS_ADDRESS_WIDTH-1:0]            address_i,
  input  logic [BUS_DATA_WIDTH-1:0]               data_i,
  input  logic [BUS_SEL_WIDTH-1:0]                sel_i,
  input  logic                                    we_i,
  input  logic [N_BITS_BURST_LENGTH-1:0]          burst_length_i,
  input  logic                                    chunk_valid_i,
  input  logic                                    last_chunk_i,
  input  logic                                    abort_i,
  output logic                                    accept_o,
  output logic                                    overflow_o,
  output logic                                    r_msg_to_pkt_o,
  output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] out_link_o,
  output logic [2:0]                              out_length_o,
  input  logic                                    g_msg_to_pkt_i
);

  localparam int DATA_BUF_WIDTH = MAX_BURST_LENGTH * BUS_DATA_WIDTH;
  localparam int PAD_WIDTH = FLIT_WIDTH - 2 - BUS_ADDRESS_WIDTH - BUS_SEL_WIDTH - 1
                             - N_BITS_BURST_LENGTH;
  localparam logic [N_BITS_BURST_LENGTH-1:0] MAX_COUNT = N_BITS_BURST_LENGTH'(MAX_BURST_LENGTH);
  localparam logic [N_BITS_POINTER-1:0]      LAST_PTR  = N_BITS_POINTER'(QUEUE_DEPTH - 1);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                           state_q, state_d;
  logic [QUEUE_DEPTH-1:0]           valid_q, valid_d;
  logic [N_BITS_POINTER-1:0]        head_q, head_d, tail_q, tail_d;
  logic [N_BITS_BURST_LENGTH-1:0]   chunk_count_q, chunk_count_d;
  logic                             overflow_q, overflow_d;

  logic [BUS_ADDRESS_WIDTH-1:0]     addr_q [QUEUE_DEPTH];
  logic [BUS_ADDRESS_WIDTH-1:0]     addr_d [QUEUE_DEPTH];
  logic [BUS_SEL_WIDTH-1:0]         sel_q  [QUEUE_DEPTH];
  logic [BUS_SEL_WIDTH-1:0]         sel_d  [QUEUE_DEPTH];
  logic                             we_q   [QUEUE_DEPTH];
  logic                             we_d   [QUEUE_DEPTH];
  logic [N_BITS_BURST_LENGTH-1:0]   len_q  [QUEUE_DEPTH];
  logic [N_BITS_BURST_LENGTH-1:0]   len_d  [QUEUE_DEPTH];
  logic [DATA_BUF_WIDTH-1:0]        data_q [QUEUE_DEPTH];
  logic [DATA_BUF_WIDTH-1:0]        data_d [QUEUE_DEPTH];

  logic                             take;
  logic [N_BITS_BURST_LENGTH:0]     len_round;

  function automatic logic [N_BITS_POINTER-1:0] next_ptr(input logic [N_BITS_POINTER-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign accept_o       = !valid_q[tail_q];
  assign r_msg_to_pkt_o = valid_q[head_q];
  assign overflow_o     = overflow_q;
  assign take           = chunk_valid_i && accept_o && !abort_i;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    head_d        = head_q;
    tail_d        = tail_q;
    chunk_count_d = chunk_count_q;
    overflow_d    = 1'b0;
    addr_d        = addr_q;
    sel_d         = sel_q;
    we_d          = we_q;
    len_d         = len_q;
    data_d        = data_q;

    if (abort_i) begin
      // The half-built slot is simply left behind; tail never moved, so it is reused.
      state_d       = IDLE;
      chunk_count_d = '0;
    end else if (take) begin
      if (state_q == IDLE) begin
        addr_d[tail_q] = address_i;
        sel_d[tail_q]  = sel_i;
        we_d[tail_q]   = we_i;
        len_d[tail_q]  = we_i ? N_BITS_BURST_LENGTH'(1) : burst_length_i;
        data_d[tail_q] = DATA_BUF_WIDTH'(data_i);
        chunk_count_d  = N_BITS_BURST_LENGTH'(1);
        state_d        = COLLECT;
      end else if (chunk_count_q < MAX_COUNT) begin
        data_d[tail_q][int'(chunk_count_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = data_i;
        chunk_count_d = chunk_count_q + 1'b1;
        if (we_q[tail_q]) len_d[tail_q] = chunk_count_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end

      if (last_chunk_i) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = next_ptr(tail_q);
        state_d         = IDLE;
        chunk_count_d   = '0;
      end
    end

    // Commit targets an empty slot and grant a full one, so they never collide.
    if (g_msg_to_pkt_i && valid_q[head_q]) begin
      valid_d[head_q] = 1'b0;
      head_d          = next_ptr(head_q);
    end
  end

  always_comb begin
    out_link_o   = '0;
    out_length_o = '0;
    len_round    = {1'b0, len_q[head_q]} + 1'b1;
    if (valid_q[head_q]) begin
      out_link_o = {data_q[head_q], (we_q[head_q] ? 2'b01 : 2'b11), {PAD_WIDTH{1'b0}},
                    len_q[head_q], we_q[head_q], sel_q[head_q], addr_q[head_q]};
      out_length_o = we_q[head_q] ? 3'd1 + 3'(len_round >> 1) : 3'd1;
    end
  end

  // NOTE: slot storage is reset too, so uncollected chunks of a fresh message read as zero
  // and nothing from before reset can leak out; state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      chunk_count_q <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        addr_q[i] <= '0;
        sel_q[i]  <= '0;
        we_q[i]   <= 1'b0;
        len_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      chunk_count_q <= chunk_count_d;
      overflow_q    <= overflow_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      len_q         <= len_d;
      data_q        <= data_d;
    end
  end

endmodule
